// File: rtl/btn_pkg.sv
// Shared definitions for the button step generator: direction codes, FSM states, helpers.
package btn_pkg;

  localparam logic [3:0] DIR_U    = 4'b1000;
  localparam logic [3:0] DIR_D    = 4'b0100;
  localparam logic [3:0] DIR_R    = 4'b0010;
  localparam logic [3:0] DIR_L    = 4'b0001;
  localparam logic [3:0] DIR_NONE = 4'b0000;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFire   = 2'd1,
    StDelay  = 2'd2,
    StRepeat = 2'd3
  } btn_state_e;

  // A cycle count of zero would make a counter never expire; clamp it to one.
  function automatic logic [31:0] sat_cycles(int unsigned cycles);
    return (cycles == 0) ? 32'd1 : 32'(cycles);
  endfunction

  // Debounced bits are {U,D,R,L}; the highest-priority press wins.
  function automatic logic [3:0] prio_encode(logic [3:0] db);
    logic [3:0] code;
    if (db[3]) begin
      code = DIR_U;
    end else if (db[2]) begin
      code = DIR_D;
    end else if (db[1]) begin
      code = DIR_R;
    end else if (db[0]) begin
      code = DIR_L;
    end else begin
      code = DIR_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchronizer followed by a stable-level debounce counter.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic db_o
);

  localparam logic [31:0] CntLast = sat_cycles(DEBOUNCE_CYCLES) - 32'd1;

  logic        sync1_q, sync2_q;
  logic        db_q, db_d;
  logic [31:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // The counter tracks how long the synchronized level has disagreed with db_q.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CntLast) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/btn_step_gen.sv
// Debounced pushbuttons to single-cycle move strobes with optional auto-repeat.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module btn_step_gen
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 30000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btns_o,
  output logic       step_o,
  output logic       held_o
);

  localparam logic [31:0] DelayLoad  = sat_cycles(REPEAT_DELAY) - 32'd1;
  localparam logic [31:0] PeriodLoad = sat_cycles(REPEAT_PERIOD) - 32'd1;

  logic [3:0]  db;
  logic [3:0]  code;
  logic        timeout;

  btn_state_e  state_q, state_d;
  logic [3:0]  code_q, code_d;
  logic [31:0] cnt_q, cnt_d;
  logic        rpt_q, rpt_d;

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i (clk),
      .rst_ni(rst_n),
      .raw_i (btn_raw[i]),
      .db_o  (db[i])
    );
  end

  assign code   = prio_encode(db);
  assign held_o = |db;

`ifdef BTN_AUTOREPEAT_EN
  assign timeout = (cnt_q == '0);
`else
  assign timeout = 1'b0;
`endif

  // rpt_q tells FIRE whether it was reached by a timer expiry (go on repeating)
  // or by a fresh code (restart the initial delay).
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    step_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        code_d = DIR_NONE;
        if (code != DIR_NONE) begin
          state_d = StFire;
          code_d  = code;
          rpt_d   = 1'b0;
        end
      end
      StFire: begin
        step_o = 1'b1;
        if (rpt_q) begin
          state_d = StRepeat;
          cnt_d   = PeriodLoad;
        end else begin
          state_d = StDelay;
          cnt_d   = DelayLoad;
        end
      end
      StDelay, StRepeat: begin
        if (code == DIR_NONE) begin
          state_d = StIdle;
          code_d  = DIR_NONE;
        end else if (code != code_q) begin
          state_d = StFire;
          code_d  = code;
          rpt_d   = 1'b0;
        end else if (timeout) begin
          state_d = StFire;
          rpt_d   = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = StIdle;
        code_d  = DIR_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      code_q  <= DIR_NONE;
      cnt_q   <= '0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
    end
  end

  assign btns_o = code_q;

endmodule

// File: tb/tb_btn_step_gen.sv
// Randomized bench for btn_step_gen against an event-time reference model.
module tb_btn_step_gen;

  localparam int unsigned Db = 4;
  localparam int unsigned Rd = 10;
  localparam int unsigned Rp = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btns_o;
  logic       step_o;
  logic       held_o;

  int checks = 0;
  int failures = 0;

  btn_step_gen #(
    .DEBOUNCE_CYCLES(Db),
    .REPEAT_DELAY   (Rd),
    .REPEAT_PERIOD  (Rp)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_raw),
    .btns_o (btns_o),
    .step_o (step_o),
    .held_o (held_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw delayed two edges, a level flips once the last Db
  // synchronized samples all disagree with it, and steps are scheduled by
  // absolute cycle numbers.
  logic [3:0] m_s1, m_s2, m_db, m_code;
  logic [3:0] m_hist[$];
  int         m_cyc, m_fire_t, m_due;
  bit         m_active, m_step;

  function automatic logic [3:0] top_code(input logic [3:0] db);
    for (int b = 3; b >= 0; b--) begin
      if (db[b]) return 4'(1 << b);
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_code = '0;
    m_hist.delete();
    m_cyc = 0; m_fire_t = 0; m_due = 0;
    m_active = 1'b0; m_step = 1'b0;
  endtask

  task automatic model_fire(input logic [3:0] c);
    m_step   = 1'b1;
    m_active = 1'b1;
    m_code   = c;
    m_fire_t = m_cyc;
    m_due    = m_cyc + int'(Rd) + 1;
  endtask

  task automatic model_edge(input logic [3:0] raw);
    logic [3:0] c;
    bit         all_diff;
    c = top_code(m_db);
    m_cyc++;
    m_step = 1'b0;
    if (!m_active) begin
      if (c != 0) model_fire(c);
    end else if (m_cyc > m_fire_t + 1) begin
      if (c == 0) begin
        m_active = 1'b0;
        m_code   = '0;
      end else if (c != m_code) begin
        model_fire(c);
      end else if (AutoRep && m_cyc == m_due) begin
        m_step   = 1'b1;
        m_fire_t = m_cyc;
        m_due    = m_cyc + int'(Rp) + 1;
      end
    end
    m_hist.push_back(m_s2);
    if (m_hist.size() > int'(Db)) void'(m_hist.pop_front());
    if (m_hist.size() == int'(Db)) begin
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        foreach (m_hist[k]) if (m_hist[k][b] == m_db[b]) all_diff = 1'b0;
        if (all_diff) m_db[b] = ~m_db[b];
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic run_cycle(input logic [3:0] raw, output logic stepped);
    btn_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    check_val("step", 32'(step_o), 32'(m_step));
    check_val("btns", 32'(btns_o), 32'(m_code));
    check_val("held", 32'(held_o), 32'(|m_db));
    stepped = step_o;
    @(negedge clk);
  endtask

  task automatic run_seg(input logic [3:0] raw, input int n);
    logic s;
    for (int i = 0; i < n; i++) run_cycle(raw, s);
  endtask

  initial begin
    logic s;
    int   first, nsteps;
    logic [3:0] v;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_btns", 32'(btns_o), 32'h0);
    check_val("rst_step", 32'(step_o), 32'h0);
    check_val("rst_held", 32'(held_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_seg(4'b0000, 5);

    // Clean R press: first step lands 2+4+1 edges after the change.
    first = -1;
    nsteps = 0;
    for (int i = 1; i <= 20; i++) begin
      run_cycle(4'b0010, s);
      if (s) begin
        nsteps++;
        if (first < 0) first = i;
      end
    end
    check_val("r_first_step", 32'(first), 32'd7);
    check_val("r_step_count", 32'(nsteps), AutoRep ? 32'd2 : 32'd1);
    run_seg(4'b0000, 20);

    // U bouncing with 2-cycle pulses before settling.
    run_seg(4'b1000, 2);
    run_seg(4'b0000, 2);
    run_seg(4'b1000, 15);
    run_seg(4'b0000, 20);

    // Long L hold, then D with U added on top.
    run_seg(4'b0001, 40);
    run_seg(4'b0000, 20);
    run_seg(4'b0100, 20);
    run_seg(4'b1100, 20);
    run_seg(4'b0000, 20);

    // Asynchronous reset while repeating, button kept held throughout.
    run_seg(4'b0001, 25);
    btn_raw = 4'b0001;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_btns", 32'(btns_o), 32'h0);
    check_val("arst_step", 32'(step_o), 32'h0);
    check_val("arst_held", 32'(held_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_seg(4'b0001, 20);
    run_seg(4'b0000, 15);

    // Random presses, combos and short bounces.
    for (int seg = 0; seg < 60; seg++) begin
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) run_seg(v, int'($urandom_range(1, 3)));
      else run_seg(v, int'($urandom_range(4, 30)));
    end
    run_seg(4'b0000, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
